// File: rtl/sa_cache_tag_model.sv
// N-way set-associative tag/lookup model with LRU or FIFO replacement,
// saturating hit/miss statistics and a set-by-set flush sequencer.
//   state  | meaning
//   IDLE   | accept a request, or start a flush
//   LOOKUP | compare tags in the indexed set, pick hit way or victim
//   UPDATE | fill on miss, update ranks/pointer, counters and response
//   FLUSH  | invalidate one set per cycle
module sa_cache_tag_model #(
  parameter int WAYS     = 4,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2,
  parameter int COUNT_W  = 32,
  parameter int POLICY   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic                     flush,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [$clog2(WAYS)-1:0]  resp_way,
  output logic                     busy,
  output logic [COUNT_W-1:0]       hit_count,
  output logic [COUNT_W-1:0]       miss_count
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = 32 - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_FLUSH} state_t;

  state_t state, state_nxt;

  logic [SETS-1:0][WAYS-1:0] line_valid;
  logic [TAG_W-1:0]          line_tag [SETS][WAYS];
  logic [WAY_W-1:0]          rank     [SETS][WAYS];
  logic [WAY_W-1:0]          fifo_ptr [SETS];

  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic               hit_q;
  logic [WAY_W-1:0]   way_q;
  logic               flush_pending;
  logic [INDEX_W-1:0] flush_idx;

  logic               lk_hit;
  logic [WAY_W-1:0]   lk_hit_way;
  logic               lk_inv;
  logic [WAY_W-1:0]   lk_inv_way;
  logic [WAY_W-1:0]   lru_way;
  logic [WAY_W-1:0]   victim;
  logic               accept;
  logic               unused_offset;

  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  assign req_ready = (state == S_IDLE) && !flush && !flush_pending;
  assign busy      = (state != S_IDLE) || flush_pending;
  assign accept    = req_valid && req_ready;

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    lk_hit     = 1'b0;
    lk_hit_way = '0;
    lk_inv     = 1'b0;
    lk_inv_way = '0;
    lru_way    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (line_valid[idx_q][w] && (line_tag[idx_q][w] == tag_q)) begin
        lk_hit     = 1'b1;
        lk_hit_way = WAY_W'(w);
      end
      if (!line_valid[idx_q][w]) begin
        lk_inv     = 1'b1;
        lk_inv_way = WAY_W'(w);
      end
      if (rank[idx_q][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    if (lk_inv)           victim = lk_inv_way;
    else if (POLICY == 0) victim = lru_way;
    else                  victim = fifo_ptr[idx_q];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (flush || flush_pending) state_nxt = S_FLUSH;
        else if (req_valid)         state_nxt = S_LOOKUP;
      end
      S_LOOKUP: state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_IDLE;
      S_FLUSH:  if (flush_idx == INDEX_W'(SETS - 1)) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q         <= '0;
      idx_q         <= '0;
      hit_q         <= 1'b0;
      way_q         <= '0;
      flush_pending <= 1'b0;
      flush_idx     <= '0;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_way      <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        tag_q <= req_addr[31:INDEX_W+OFFSET_W];
        idx_q <= req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
      end
      if (state == S_LOOKUP) begin
        hit_q <= lk_hit;
        way_q <= lk_hit ? lk_hit_way : victim;
      end
      if (flush && (state == S_LOOKUP || state == S_UPDATE)) flush_pending <= 1'b1;
      else if (state == S_IDLE)                             flush_pending <= 1'b0;
      if (state == S_FLUSH) flush_idx <= flush_idx + 1'b1;
      else                  flush_idx <= '0;
      if (state == S_UPDATE) begin
        resp_valid <= 1'b1;
        resp_hit   <= hit_q;
        resp_way   <= way_q;
        if (hit_q) begin
          if (hit_count != '1) hit_count <= hit_count + COUNT_W'(1);
        end else begin
          if (miss_count != '1) miss_count <= miss_count + COUNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid <= '0;
      for (int s = 0; s < SETS; s++) begin
        fifo_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) rank[s][w] <= WAY_W'(w);
      end
    end else if (state == S_UPDATE) begin
      if (!hit_q) line_valid[idx_q][way_q] <= 1'b1;
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == way_q)                      rank[idx_q][w] <= '0;
        else if (rank[idx_q][w] < rank[idx_q][way_q]) rank[idx_q][w] <= rank[idx_q][w] + 1'b1;
      end
      // FIFO pointer only moves when the fill consumed the way it points at.
      if (POLICY != 0 && !hit_q && (way_q == fifo_ptr[idx_q]))
        fifo_ptr[idx_q] <= fifo_ptr[idx_q] + 1'b1;
    end else if (state == S_FLUSH) begin
      fifo_ptr[flush_idx] <= '0;
      for (int w = 0; w < WAYS; w++) begin
        line_valid[flush_idx][w] <= 1'b0;
        rank[flush_idx][w]       <= WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_UPDATE && !hit_q) line_tag[idx_q][way_q] <= tag_q;
  end

endmodule
